// File: rtl/coherency_arbiter_n.sv
// Snooping coherency controller: round-robin arbitration of NCPU I/D cache pairs onto one
// shared single-port RAM, with multi-word block transfers and cache-to-cache supply.
module coherency_arbiter_n #(
  parameter int NCPU        = 2,
  parameter int WORD_W      = 32,
  parameter int BLOCK_WORDS = 2
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic [NCPU-1:0]          iREN,
  input  logic [NCPU*WORD_W-1:0]   iaddr,
  input  logic [NCPU-1:0]          dREN,
  input  logic [NCPU-1:0]          dWEN,
  input  logic [NCPU*WORD_W-1:0]   daddr,
  input  logic [NCPU*WORD_W-1:0]   dstore,
  input  logic [NCPU-1:0]          ccwrite,
  input  logic [NCPU-1:0]          snoop_dirty,
  output logic [NCPU-1:0]          iwait,
  output logic [NCPU-1:0]          dwait,
  output logic [NCPU*WORD_W-1:0]   iload,
  output logic [NCPU*WORD_W-1:0]   dload,
  output logic [NCPU-1:0]          ccwait,
  output logic [NCPU-1:0]          ccinv,
  output logic [NCPU*WORD_W-1:0]   ccsnoopaddr,
  output logic                     ramREN,
  output logic                     ramWEN,
  output logic [WORD_W-1:0]        ramaddr,
  output logic [WORD_W-1:0]        ramstore,
  input  logic [WORD_W-1:0]        ramload,
  input  logic [1:0]               ramstate
);

  localparam int PTR_W = (NCPU > 1) ? $clog2(NCPU) : 1;
  localparam int CNT_W = (BLOCK_WORDS > 1) ? $clog2(BLOCK_WORDS) : 1;
  localparam logic [WORD_W-1:0] BLK_MASK = WORD_W'(BLOCK_WORDS * 4 - 1);
  localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(BLOCK_WORDS - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_IFETCH, S_WB, S_SNOOP1, S_SNOOP2, S_M2C, S_C2C
  } state_t;

  state_t           r_state;
  logic [PTR_W-1:0] r_owner;
  logic [PTR_W-1:0] r_supplier;
  logic [PTR_W-1:0] r_rr_ptr;
  logic [CNT_W-1:0] r_word_cnt;

  logic [WORD_W-1:0] w_iaddr  [NCPU];
  logic [WORD_W-1:0] w_daddr  [NCPU];
  logic [WORD_W-1:0] w_dstore [NCPU];
  logic [NCPU-1:0]   w_any_req;

  for (genvar gi = 0; gi < NCPU; gi++) begin : g_unpack
    assign w_iaddr[gi]   = iaddr[gi*WORD_W +: WORD_W];
    assign w_daddr[gi]   = daddr[gi*WORD_W +: WORD_W];
    assign w_dstore[gi]  = dstore[gi*WORD_W +: WORD_W];
    assign w_any_req[gi] = iREN[gi] | dREN[gi] | dWEN[gi];
  end

  logic              w_access;
  logic              w_last;
  logic [WORD_W-1:0] w_owner_daddr;
  logic [WORD_W-1:0] w_blk_addr;
  logic [PTR_W-1:0]  w_next_rr;

  assign w_access      = (ramstate == 2'd2);
  assign w_last        = (r_state == S_IFETCH) || (r_word_cnt == LAST_CNT);
  assign w_owner_daddr = w_daddr[r_owner];
  assign w_blk_addr    = (w_owner_daddr & ~BLK_MASK) | (WORD_W'(r_word_cnt) << 2);
  assign w_next_rr     = (r_owner == PTR_W'(NCPU - 1)) ? '0 : r_owner + 1'b1;

  // Round-robin scan starting at r_rr_ptr, wrapping modulo NCPU.
  logic             w_found;
  logic [PTR_W-1:0] w_pick;
  logic [PTR_W:0]   w_idx;
  always_comb begin
    w_found = 1'b0;
    w_pick  = '0;
    w_idx   = '0;
    for (int k = 0; k < NCPU; k++) begin
      w_idx = {1'b0, r_rr_ptr} + (PTR_W+1)'(k);
      if (w_idx >= (PTR_W+1)'(NCPU)) w_idx = w_idx - (PTR_W+1)'(NCPU);
      if (!w_found && w_any_req[w_idx[PTR_W-1:0]]) begin
        w_found = 1'b1;
        w_pick  = w_idx[PTR_W-1:0];
      end
    end
  end

  logic             w_dirty_found;
  logic [PTR_W-1:0] w_dirty_idx;
  always_comb begin
    w_dirty_found = 1'b0;
    w_dirty_idx   = '0;
    for (int j = NCPU - 1; j >= 0; j--) begin
      if (snoop_dirty[j] && (PTR_W'(j) != r_owner)) begin
        w_dirty_found = 1'b1;
        w_dirty_idx   = PTR_W'(j);
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state    <= S_IDLE;
      r_owner    <= '0;
      r_supplier <= '0;
      r_rr_ptr   <= '0;
      r_word_cnt <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_found) begin
            r_owner    <= w_pick;
            r_word_cnt <= '0;
            if (dWEN[w_pick])      r_state <= S_WB;
            else if (dREN[w_pick]) r_state <= S_SNOOP1;
            else                   r_state <= S_IFETCH;
          end
        end
        S_SNOOP1: r_state <= S_SNOOP2;
        S_SNOOP2: begin
          if (w_dirty_found) begin
            r_supplier <= w_dirty_idx;
            r_state    <= S_C2C;
          end else begin
            r_state <= S_M2C;
          end
        end
        default: begin
          // FREE, BUSY and ERROR all hold the current word; only ACCESS advances.
          if (w_access) begin
            if (w_last) begin
              r_state    <= S_IDLE;
              r_word_cnt <= '0;
              r_rr_ptr   <= w_next_rr;
            end else begin
              r_word_cnt <= r_word_cnt + 1'b1;
            end
          end
        end
      endcase
    end
  end

  always_comb begin
    iwait       = '1;
    dwait       = '1;
    iload       = '0;
    dload       = '0;
    ccwait      = '0;
    ccinv       = '0;
    ccsnoopaddr = '0;
    ramREN      = 1'b0;
    ramWEN      = 1'b0;
    ramaddr     = '0;
    ramstore    = '0;
    case (r_state)
      S_IFETCH: begin
        ramREN  = 1'b1;
        ramaddr = w_iaddr[r_owner];
        iload[r_owner*WORD_W +: WORD_W] = ramload;
        if (w_access) iwait[r_owner] = 1'b0;
      end
      S_WB: begin
        ramWEN   = 1'b1;
        ramaddr  = w_blk_addr;
        ramstore = w_dstore[r_owner];
        if (w_access) dwait[r_owner] = 1'b0;
      end
      S_SNOOP1, S_SNOOP2: begin
        for (int j = 0; j < NCPU; j++) begin
          if (PTR_W'(j) != r_owner) begin
            ccwait[j] = 1'b1;
            ccinv[j]  = ccwrite[r_owner];
            ccsnoopaddr[j*WORD_W +: WORD_W] = w_owner_daddr;
          end
        end
      end
      S_M2C: begin
        ramREN  = 1'b1;
        ramaddr = w_blk_addr;
        dload[r_owner*WORD_W +: WORD_W] = ramload;
        if (w_access) dwait[r_owner] = 1'b0;
      end
      S_C2C: begin
        // Supplier's word goes to the requester and is written back to RAM at once.
        ramWEN   = 1'b1;
        ramaddr  = w_blk_addr;
        ramstore = w_dstore[r_supplier];
        dload[r_owner*WORD_W +: WORD_W] = w_dstore[r_supplier];
        ccwait[r_supplier] = 1'b1;
        ccsnoopaddr[r_supplier*WORD_W +: WORD_W] = w_owner_daddr;
        if (w_access) begin
          dwait[r_owner]    = 1'b0;
          dwait[r_supplier] = 1'b0;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_coherency_arbiter_n.sv
// Bench for coherency_arbiter_n: directed scenarios with literal expectations, then random
// traffic, all checked every cycle against a transaction-level model.
module tb_coherency_arbiter_n;
  localparam int N  = 2;
  localparam int W  = 32;
  localparam int BW = 2;
  typedef logic [N*W-1:0] vec_t;

  logic CLK = 1'b0;
  logic RST;
  logic [N-1:0]   iREN, dREN, dWEN, ccwrite, snoop_dirty;
  logic [N*W-1:0] iaddr, daddr, dstore;
  logic [N-1:0]   iwait, dwait, ccwait, ccinv;
  logic [N*W-1:0] iload, dload, ccsnoopaddr;
  logic           ramREN, ramWEN;
  logic [W-1:0]   ramaddr, ramstore, ramload;
  logic [1:0]     ramstate;

  coherency_arbiter_n #(.NCPU(N), .WORD_W(W), .BLOCK_WORDS(BW)) dut (
    .CLK(CLK), .RST(RST), .iREN(iREN), .iaddr(iaddr), .dREN(dREN), .dWEN(dWEN),
    .daddr(daddr), .dstore(dstore), .ccwrite(ccwrite), .snoop_dirty(snoop_dirty),
    .iwait(iwait), .dwait(dwait), .iload(iload), .dload(dload), .ccwait(ccwait),
    .ccinv(ccinv), .ccsnoopaddr(ccsnoopaddr), .ramREN(ramREN), .ramWEN(ramWEN),
    .ramaddr(ramaddr), .ramstore(ramstore), .ramload(ramload), .ramstate(ramstate)
  );

  always #5 CLK = ~CLK;

  int vectors = 0;
  int miscompares = 0;
  bit run_cmp = 1'b0;
  bit rnd_mode = 1'b0;

  // Requester-side state: each core holds a request until the model says it completed.
  bit           ireq [N];
  int           dk   [N];   // 0 none, 1 read, 2 writeback
  bit           ccw  [N];
  logic [W-1:0] ia [N], da [N], ds [N];
  logic [W-1:0] rl;
  logic [1:0]   rs;
  logic [N-1:0] sd;

  // Model: current transaction kind 0 none, 1 ifetch, 2 wb, 3 snoop, 4 m2c, 5 c2c.
  int m_kind, m_own, m_sup, m_words, m_scyc, m_rr;

  task automatic check(string name, vec_t act, vec_t exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic apply();
    for (int k = 0; k < N; k++) begin
      iREN[k]        = ireq[k];
      dREN[k]        = (dk[k] == 1);
      dWEN[k]        = (dk[k] == 2);
      ccwrite[k]     = ccw[k] && (dk[k] == 1);
      iaddr[k*W +: W]  = ia[k];
      daddr[k*W +: W]  = da[k];
      dstore[k*W +: W] = ds[k];
    end
    ramload = rl; ramstate = rs; snoop_dirty = sd;
  endtask

  task automatic model_reset();
    m_kind = 0; m_own = 0; m_sup = 0; m_words = 0; m_scyc = 0; m_rr = 0;
    for (int k = 0; k < N; k++) begin
      ireq[k] = 0; dk[k] = 0; ccw[k] = 0; ia[k] = '0; da[k] = '0; ds[k] = '0;
    end
    sd = '0;
  endtask

  task automatic model_advance();
    bit found;
    int sup;
    if (m_kind == 0) begin
      found = 0;
      for (int k = 0; k < N; k++) begin
        int c;
        c = (m_rr + k) % N;
        if (!found && (iREN[c] || dREN[c] || dWEN[c])) begin
          found = 1; m_own = c; m_words = 0; m_scyc = 0;
          m_kind = dWEN[c] ? 2 : (dREN[c] ? 3 : 1);
        end
      end
    end else if (m_kind == 3) begin
      if (m_scyc == 0) m_scyc = 1;
      else begin
        sup = -1;
        for (int j = N - 1; j >= 0; j--) if (j != m_own && snoop_dirty[j]) sup = j;
        if (sup >= 0) begin m_kind = 5; m_sup = sup; end
        else m_kind = 4;
      end
    end else if (ramstate == 2'd2) begin
      m_words++;
      if (m_words == ((m_kind == 1) ? 1 : BW)) begin
        if (m_kind == 1) ireq[m_own] = 0; else dk[m_own] = 0;
        m_rr = (m_own + 1) % N;
        m_kind = 0; m_words = 0;
      end
    end
  endtask

  task automatic randomize_inputs();
    int r;
    rl = $urandom;
    r = $urandom_range(0, 7);
    rs = (r < 3) ? 2'(r) : 2'd2;
    sd = N'($urandom);
    for (int k = 0; k < N; k++) begin
      ds[k] = $urandom;
      if (!ireq[k] && $urandom_range(0, 5) == 0) begin
        ireq[k] = 1; ia[k] = $urandom & ~32'h3;
      end
      if (dk[k] == 0 && $urandom_range(0, 5) == 0) begin
        dk[k] = $urandom_range(1, 2); da[k] = $urandom & ~32'h3; ccw[k] = 1'($urandom);
      end
    end
  endtask

  task automatic step();
    @(posedge CLK);
    if (!RST) model_advance();
    #1;
    if (rnd_mode) randomize_inputs();
    apply();
    @(negedge CLK);
  endtask

  // Per-cycle comparison of every output against the model's view.
  initial begin
    logic [N-1:0] e_iwait, e_dwait, e_ccwait, e_ccinv;
    vec_t e_iload, e_dload, e_snp;
    logic e_ren, e_wen;
    logic [W-1:0] e_addr, e_store, blk;
    bit acc;
    int o;
    forever begin
      @(negedge CLK);
      if (run_cmp) begin
        e_iwait = '1; e_dwait = '1; e_ccwait = '0; e_ccinv = '0;
        e_iload = '0; e_dload = '0; e_snp = '0;
        e_ren = 0; e_wen = 0; e_addr = '0; e_store = '0;
        o = m_own;
        acc = (ramstate == 2'd2);
        blk = (daddr[o*W +: W] & ~W'(BW*4 - 1)) + W'(m_words * 4);
        case (m_kind)
          1: begin
            e_ren = 1; e_addr = iaddr[o*W +: W]; e_iload[o*W +: W] = ramload;
            if (acc) e_iwait[o] = 0;
          end
          2: begin
            e_wen = 1; e_addr = blk; e_store = dstore[o*W +: W];
            if (acc) e_dwait[o] = 0;
          end
          3: for (int j = 0; j < N; j++) if (j != o) begin
            e_ccwait[j] = 1; e_ccinv[j] = ccwrite[o]; e_snp[j*W +: W] = daddr[o*W +: W];
          end
          4: begin
            e_ren = 1; e_addr = blk; e_dload[o*W +: W] = ramload;
            if (acc) e_dwait[o] = 0;
          end
          5: begin
            e_wen = 1; e_addr = blk; e_store = dstore[m_sup*W +: W];
            e_dload[o*W +: W] = dstore[m_sup*W +: W];
            e_ccwait[m_sup] = 1; e_snp[m_sup*W +: W] = daddr[o*W +: W];
            if (acc) begin e_dwait[o] = 0; e_dwait[m_sup] = 0; end
          end
          default: ;
        endcase
        check("iwait", vec_t'(iwait), vec_t'(e_iwait));
        check("dwait", vec_t'(dwait), vec_t'(e_dwait));
        check("iload", iload, e_iload);
        check("dload", dload, e_dload);
        check("ccwait", vec_t'(ccwait), vec_t'(e_ccwait));
        check("ccinv", vec_t'(ccinv), vec_t'(e_ccinv));
        check("ccsnoopaddr", ccsnoopaddr, e_snp);
        check("ramREN", vec_t'(ramREN), vec_t'(e_ren));
        check("ramWEN", vec_t'(ramWEN), vec_t'(e_wen));
        check("ramaddr", vec_t'(ramaddr), vec_t'(e_addr));
        check("ramstore", vec_t'(ramstore), vec_t'(e_store));
      end
    end
  end

  initial begin
    RST = 1'b1;
    model_reset();
    rl = 32'h1111_1111; rs = 2'd2;
    apply();
    run_cmp = 1'b1;
    step(); step();
    check("reset_iwait", vec_t'(iwait), vec_t'(2'b11));
    check("reset_dwait", vec_t'(dwait), vec_t'(2'b11));
    #2 RST = 1'b0;

    // Clean miss from core0: two snoop cycles, then two RAM reads.
    dk[0] = 1; da[0] = 32'h100;
    step(); check("d1_idle_ccwait", vec_t'(ccwait), vec_t'(2'b00));
    step(); check("d1_snoop1_ccwait", vec_t'(ccwait), vec_t'(2'b10));
    check("d1_snoopaddr", vec_t'(ccsnoopaddr[W +: W]), vec_t'(32'h100));
    step(); check("d1_snoop2_ccwait", vec_t'(ccwait), vec_t'(2'b10));
    step(); check("d1_w0_addr", vec_t'(ramaddr), vec_t'(32'h100));
    check("d1_w0_dwait", vec_t'(dwait), vec_t'(2'b10));
    check("d1_w0_dload", vec_t'(dload[W-1:0]), vec_t'(32'h1111_1111));
    step(); check("d1_w1_addr", vec_t'(ramaddr), vec_t'(32'h104));
    step(); check("d1_done_ren", vec_t'(ramREN), vec_t'(1'b0));

    // Read-for-write from core1, core0 holds the line dirty and supplies it.
    dk[1] = 1; da[1] = 32'h200; ccw[1] = 1; sd = 2'b01; ds[0] = 32'hDEAD;
    step();
    step(); check("d2_ccinv", vec_t'(ccinv), vec_t'(2'b01));
    check("d2_ccwait", vec_t'(ccwait), vec_t'(2'b01));
    step();
    step(); check("d2_w0_wen", vec_t'(ramWEN), vec_t'(1'b1));
    check("d2_w0_store", vec_t'(ramstore), vec_t'(32'hDEAD));
    check("d2_w0_addr", vec_t'(ramaddr), vec_t'(32'h200));
    check("d2_w0_dload", vec_t'(dload[W +: W]), vec_t'(32'hDEAD));
    check("d2_w0_dwait", vec_t'(dwait), vec_t'(2'b00));
    step(); check("d2_w1_addr", vec_t'(ramaddr), vec_t'(32'h204));
    step(); check("d2_done_wen", vec_t'(ramWEN), vec_t'(1'b0));
    sd = '0; ds[0] = '0;

    // Simultaneous ifetches: core0 then core1.
    ireq[0] = 1; ia[0] = 32'h40; ireq[1] = 1; ia[1] = 32'h80;
    step();
    step(); check("d3_c0_addr", vec_t'(ramaddr), vec_t'(32'h40));
    check("d3_c0_iwait", vec_t'(iwait), vec_t'(2'b10));
    step(); check("d3_gap_ren", vec_t'(ramREN), vec_t'(1'b0));
    step(); check("d3_c1_addr", vec_t'(ramaddr), vec_t'(32'h80));
    check("d3_c1_iwait", vec_t'(iwait), vec_t'(2'b01));
    step();

    // Writeback beats ifetch on the same core.
    dk[0] = 2; da[0] = 32'h300; ds[0] = 32'h1234; ireq[0] = 1; ia[0] = 32'h44;
    step();
    step(); check("d4_w0_addr", vec_t'(ramaddr), vec_t'(32'h300));
    check("d4_w0_store", vec_t'(ramstore), vec_t'(32'h1234));
    check("d4_w0_dwait", vec_t'(dwait), vec_t'(2'b10));
    step(); check("d4_w1_addr", vec_t'(ramaddr), vec_t'(32'h304));
    step();
    step(); check("d4_if_addr", vec_t'(ramaddr), vec_t'(32'h44));
    check("d4_if_iwait", vec_t'(iwait), vec_t'(2'b10));
    step();

    // Reset during the second word of a core1 miss (rr_ptr is 1 here).
    dk[1] = 1; da[1] = 32'h500; ccw[1] = 0;
    step(); step(); step();
    step(); check("d6_w0_addr", vec_t'(ramaddr), vec_t'(32'h500));
    step(); check("d6_w1_addr", vec_t'(ramaddr), vec_t'(32'h504));
    #2 RST = 1'b1;
    model_reset();
    apply();
    #1 check("d6_rst_ren", vec_t'(ramREN), vec_t'(1'b0));
    check("d6_rst_dwait", vec_t'(dwait), vec_t'(2'b11));
    step();
    #2 RST = 1'b0;
    ireq[0] = 1; ia[0] = 32'h40; ireq[1] = 1; ia[1] = 32'h80;
    step();
    step(); check("d6_rr0_addr", vec_t'(ramaddr), vec_t'(32'h40));
    step(); step(); step();

    // RAM BUSY then ERROR before ACCESS; the word only completes on ACCESS.
    dk[1] = 1; da[1] = 32'h400; rs = 2'd1;
    step(); step(); step();
    for (int i = 0; i < 5; i++) begin
      step(); check("d5_busy_dwait", vec_t'(dwait), vec_t'(2'b11));
      check("d5_busy_addr", vec_t'(ramaddr), vec_t'(32'h400));
    end
    rs = 2'd3;
    for (int i = 0; i < 2; i++) begin
      step(); check("d5_err_dwait", vec_t'(dwait), vec_t'(2'b11));
    end
    rs = 2'd2;
    step(); check("d5_acc_dwait", vec_t'(dwait), vec_t'(2'b01));
    check("d5_acc_addr", vec_t'(ramaddr), vec_t'(32'h400));
    step(); check("d5_w1_addr", vec_t'(ramaddr), vec_t'(32'h404));
    step();

    rnd_mode = 1'b1;
    for (int i = 0; i < 3000; i++) step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
